// File: rtl/switch_crossbar_sched_pkg.sv
// Shared types and helpers for the iSLIP crossbar scheduler slice.
package switch_crossbar_sched_pkg;

  typedef enum logic {
    PAIR_FREE   = 1'b0,
    PAIR_LOCKED = 1'b1
  } pair_state_e;

  function automatic int unsigned sel_width(input int unsigned radix);
    return (radix > 1) ? $clog2(radix) : 1;
  endfunction

  // Flat bit position of the (input, output) pair in req/match.
  function automatic int unsigned pair_idx(input int unsigned i, input int unsigned o,
                                           input int unsigned radix);
    return i * radix + o;
  endfunction

endpackage

// File: rtl/switch_crossbar_sched_if.sv
// Scheduler bus: VOQ requests / eop / output enables in, match matrix and decoded selects out.
interface switch_crossbar_sched_if
  import switch_crossbar_sched_pkg::*;
#(
  parameter int unsigned RADIX     = 4,
  parameter int unsigned SEL_WIDTH = sel_width(RADIX)
);
  logic [RADIX*RADIX-1:0]     req;
  logic [RADIX-1:0]           eop;
  logic [RADIX-1:0]           out_enable;
  logic [RADIX*RADIX-1:0]     match;
  logic [RADIX-1:0]           in_busy;
  logic [RADIX-1:0]           out_busy;
  logic [RADIX*SEL_WIDTH-1:0] in_sel;
  logic [RADIX*SEL_WIDTH-1:0] out_sel;

  modport master (
    output req, eop, out_enable,
    input  match, in_busy, out_busy, in_sel, out_sel
  );

  modport slave (
    input  req, eop, out_enable,
    output match, in_busy, out_busy, in_sel, out_sel
  );
endinterface

// File: rtl/switch_rr_pick.sv
// Cyclic priority encoder: first set bit of req at or after ptr, as one-hot and index.
module switch_rr_pick #(
  parameter int unsigned REQ_WIDTH = 4,
  parameter int unsigned IDX_WIDTH = (REQ_WIDTH > 1) ? $clog2(REQ_WIDTH) : 1
) (
  input  logic [IDX_WIDTH-1:0] ptr,
  input  logic [REQ_WIDTH-1:0] req,
  output logic [REQ_WIDTH-1:0] gnt,
  output logic [IDX_WIDTH-1:0] idx
);

  logic                 found;
  logic [IDX_WIDTH-1:0] pos;

  // Walk positions by explicit wrap instead of modulo so non-power-of-2 widths stay exact.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = ptr;
    for (int unsigned k = 0; k < REQ_WIDTH; k++) begin
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
      pos = (pos == IDX_WIDTH'(REQ_WIDTH - 1)) ? '0 : pos + 1'b1;
    end
  end

endmodule

// File: rtl/switch_crossbar_sched.sv
// Single-iteration iSLIP scheduler with per-packet locking of matched input/output pairs.
module switch_crossbar_sched
  import switch_crossbar_sched_pkg::*;
#(
  parameter int unsigned RADIX     = 4,
  parameter int unsigned SEL_WIDTH = sel_width(RADIX)
) (
  input  logic                   clk,
  input  logic                   rst,
  switch_crossbar_sched_if.slave bus
);

  pair_state_e          state_q    [RADIX][RADIX];
  pair_state_e          state_d    [RADIX][RADIX];
  logic [SEL_WIDTH-1:0] g_ptr_q    [RADIX];
  logic [SEL_WIDTH-1:0] g_ptr_d    [RADIX];
  logic [SEL_WIDTH-1:0] a_ptr_q    [RADIX];
  logic [SEL_WIDTH-1:0] a_ptr_d    [RADIX];

  logic [RADIX-1:0]     locked_row [RADIX];  // [input][output]
  logic [RADIX-1:0]     grant_req  [RADIX];  // [output][input]
  logic [RADIX-1:0]     grant      [RADIX];  // [output][input]
  logic [SEL_WIDTH-1:0] grant_idx  [RADIX];
  logic [RADIX-1:0]     accept_req [RADIX];  // [input][output]
  logic [RADIX-1:0]     accept     [RADIX];  // [input][output]
  logic [SEL_WIDTH-1:0] accept_idx [RADIX];
  logic [RADIX-1:0]     in_busy;
  logic [RADIX-1:0]     out_busy;
  logic [RADIX-1:0]     out_elig;
  logic [RADIX-1:0]     out_accepted;

  logic [RADIX*RADIX-1:0]     match_w;
  logic [RADIX*SEL_WIDTH-1:0] in_sel_w;
  logic [RADIX*SEL_WIDTH-1:0] out_sel_w;

  function automatic logic [SEL_WIDTH-1:0] ptr_inc(input logic [SEL_WIDTH-1:0] p);
    return (p == SEL_WIDTH'(RADIX - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    in_busy  = '0;
    out_busy = '0;
    for (int unsigned i = 0; i < RADIX; i++) begin
      for (int unsigned o = 0; o < RADIX; o++) begin
        locked_row[i][o] = (state_q[i][o] == PAIR_LOCKED);
        in_busy[i]       = in_busy[i]  | locked_row[i][o];
        out_busy[o]      = out_busy[o] | locked_row[i][o];
      end
    end
  end

  // Busy state comes from the registered locks, so a pair released this cycle stays ineligible.
  assign out_elig = ~out_busy & bus.out_enable;

  always_comb begin
    for (int unsigned o = 0; o < RADIX; o++) begin
      for (int unsigned i = 0; i < RADIX; i++) begin
        grant_req[o][i] = bus.req[pair_idx(i, o, RADIX)] & ~in_busy[i] & out_elig[o];
      end
    end
  end

  for (genvar o = 0; o < RADIX; o++) begin : g_grant
    switch_rr_pick #(.REQ_WIDTH(RADIX), .IDX_WIDTH(SEL_WIDTH)) u_pick (
      .ptr (g_ptr_q[o]),
      .req (grant_req[o]),
      .gnt (grant[o]),
      .idx (grant_idx[o])
    );
  end

  always_comb begin
    for (int unsigned i = 0; i < RADIX; i++) begin
      for (int unsigned o = 0; o < RADIX; o++) begin
        accept_req[i][o] = grant[o][i];
      end
    end
  end

  for (genvar i = 0; i < RADIX; i++) begin : g_accept
    switch_rr_pick #(.REQ_WIDTH(RADIX), .IDX_WIDTH(SEL_WIDTH)) u_pick (
      .ptr (a_ptr_q[i]),
      .req (accept_req[i]),
      .gnt (accept[i]),
      .idx (accept_idx[i])
    );
  end

  always_comb begin
    out_accepted = '0;
    for (int unsigned i = 0; i < RADIX; i++) begin
      out_accepted = out_accepted | accept[i];
    end
  end

  always_comb begin
    state_d = state_q;
    g_ptr_d = g_ptr_q;
    a_ptr_d = a_ptr_q;
    for (int unsigned i = 0; i < RADIX; i++) begin
      for (int unsigned o = 0; o < RADIX; o++) begin
        case (state_q[i][o])
          PAIR_FREE:   if (accept[i][o]) state_d[i][o] = PAIR_LOCKED;
          PAIR_LOCKED: if (bus.eop[i])   state_d[i][o] = PAIR_FREE;
          default:                       state_d[i][o] = PAIR_FREE;
        endcase
      end
      if (|accept[i]) a_ptr_d[i] = ptr_inc(accept_idx[i]);
    end
    // The accepted input of output o is the one it granted.
    for (int unsigned o = 0; o < RADIX; o++) begin
      if (out_accepted[o]) g_ptr_d[o] = ptr_inc(grant_idx[o]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RADIX; i++) begin
        for (int unsigned o = 0; o < RADIX; o++) begin
          state_q[i][o] <= PAIR_FREE;
        end
        g_ptr_q[i] <= '0;
        a_ptr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      g_ptr_q <= g_ptr_d;
      a_ptr_q <= a_ptr_d;
    end
  end

  always_comb begin
    match_w   = '0;
    in_sel_w  = '0;
    out_sel_w = '0;
    for (int unsigned i = 0; i < RADIX; i++) begin
      for (int unsigned o = 0; o < RADIX; o++) begin
        if (locked_row[i][o]) begin
          match_w[pair_idx(i, o, RADIX)]          = 1'b1;
          in_sel_w[i*SEL_WIDTH +: SEL_WIDTH]      = SEL_WIDTH'(o);
          out_sel_w[o*SEL_WIDTH +: SEL_WIDTH]     = SEL_WIDTH'(i);
        end
      end
    end
  end

  assign bus.match    = match_w;
  assign bus.in_busy  = in_busy;
  assign bus.out_busy = out_busy;
  assign bus.in_sel   = in_sel_w;
  assign bus.out_sel  = out_sel_w;

endmodule

// File: tb/tb_switch_crossbar_sched.sv
// Scoreboard bench for switch_crossbar_sched (RADIX=4): iSLIP reference model plus directed scenarios.
module tb_switch_crossbar_sched;

  typedef struct packed {
    logic [15:0] m;
    logic [3:0]  ib;
    logic [3:0]  ob;
    logic [7:0]  is;
    logic [7:0]  os;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  exp_t        sbq[$];
  logic [15:0] m_match;
  int          g_ptr[4];
  int          a_ptr[4];

  switch_crossbar_sched_if #(.RADIX(4)) bus ();

  switch_crossbar_sched #(.RADIX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic exp_t derive(input logic [15:0] m);
    exp_t e;
    e   = '0;
    e.m = m;
    for (int i = 0; i < 4; i++) begin
      for (int o = 0; o < 4; o++) begin
        if (m[i*4+o]) begin
          e.ib[i]       = 1'b1;
          e.ob[o]       = 1'b1;
          e.is[i*2 +: 2] = 2'(o);
          e.os[o*2 +: 2] = 2'(i);
        end
      end
    end
    return e;
  endfunction

  task automatic model_step(input logic r, input logic [15:0] rq, input logic [3:0] ep,
                            input logic [3:0] oe);
    logic [15:0] nm;
    logic [3:0]  ib, ob;
    int          gi[4];
    if (r) begin
      m_match = '0;
      for (int k = 0; k < 4; k++) begin
        g_ptr[k] = 0;
        a_ptr[k] = 0;
      end
      return;
    end
    ib = '0;
    ob = '0;
    for (int i = 0; i < 4; i++)
      for (int o = 0; o < 4; o++)
        if (m_match[i*4+o]) begin
          ib[i] = 1'b1;
          ob[o] = 1'b1;
        end
    nm = m_match;
    for (int i = 0; i < 4; i++)
      if (ep[i] && ib[i]) nm[i*4 +: 4] = 4'b0000;
    for (int o = 0; o < 4; o++) begin
      gi[o] = -1;
      if (!ob[o] && oe[o]) begin
        for (int k = 0; k < 4; k++) begin
          int i;
          i = (g_ptr[o] + k) % 4;
          if (rq[i*4+o] && !ib[i]) begin
            gi[o] = i;
            break;
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (!ib[i]) begin
        for (int k = 0; k < 4; k++) begin
          int o;
          o = (a_ptr[i] + k) % 4;
          if (gi[o] == i) begin
            nm[i*4+o] = 1'b1;
            g_ptr[o]  = (i + 1) % 4;
            a_ptr[i]  = (o + 1) % 4;
            break;
          end
        end
      end
    end
    m_match = nm;
  endtask

  task automatic cycle(input logic r, input logic [15:0] rq, input logic [3:0] ep,
                       input logic [3:0] oe);
    exp_t e;
    @(negedge clk);
    rst            = r;
    bus.req        = rq;
    bus.eop        = ep;
    bus.out_enable = oe;
    model_step(r, rq, ep, oe);
    sbq.push_back(derive(m_match));
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk("match",    32'(bus.match),    32'(e.m));
      chk("in_busy",  32'(bus.in_busy),  32'(e.ib));
      chk("out_busy", 32'(bus.out_busy), 32'(e.ob));
      chk("in_sel",   32'(bus.in_sel),   32'(e.is));
      chk("out_sel",  32'(bus.out_sel),  32'(e.os));
    end
  endtask

  initial begin
    logic [15:0] rq;
    logic [3:0]  ep;
    int          order[$];
    int          gaps[$];
    int          gap;
    logic        prev_b;
    rst            = 1'b1;
    bus.req        = '0;
    bus.eop        = '0;
    bus.out_enable = '1;

    // reset with every request asserted, then the first match uses pointers 0
    cycle(1'b1, 16'hFFFF, 4'h0, 4'hF);
    cycle(1'b1, 16'hFFFF, 4'h0, 4'hF);
    chk("rst_match", 32'(bus.match), 32'h0);
    chk("rst_sel", 32'({bus.in_sel, bus.out_sel}), 32'h0);
    cycle(1'b0, 16'hFFFF, 4'h0, 4'hF);
    chk("first_match", 32'(bus.match), 32'h0001);
    cycle(1'b0, 16'hFFFF, 4'h0, 4'hF);
    chk("second_match", 32'(bus.match), 32'h0021);

    // single pair, lock holds without req, stray eop ignored, eop releases
    cycle(1'b1, 16'h0000, 4'h0, 4'hF);
    cycle(1'b0, 16'h0040, 4'h0, 4'hF);
    chk("single_match", 32'(bus.match), 32'h0040);
    chk("single_in_sel1", 32'(bus.in_sel[3:2]), 32'd2);
    chk("single_out_sel2", 32'(bus.out_sel[5:4]), 32'd1);
    cycle(1'b0, 16'h0000, 4'h0, 4'hF);
    cycle(1'b0, 16'h0000, 4'b0101, 4'hF);
    cycle(1'b0, 16'h0000, 4'h0, 4'hF);
    chk("single_hold", 32'(bus.match), 32'h0040);
    cycle(1'b0, 16'h0000, 4'b0010, 4'hF);
    chk("single_release", 32'(bus.match), 32'h0);

    // output contention: inputs 0,1,3 -> output 2, eop one cycle after each match
    rq = 16'h4044;
    cycle(1'b1, rq, 4'h0, 4'hF);
    prev_b = 1'b0;
    gap    = -1;
    for (int c = 0; c < 30 && order.size() < 4; c++) begin
      for (int i = 0; i < 4; i++) ep[i] = |m_match[i*4 +: 4];
      cycle(1'b0, rq, ep, 4'hF);
      if (bus.out_busy[2] && !prev_b) begin
        order.push_back(int'(bus.out_sel[5:4]));
        if (gap >= 0) gaps.push_back(gap);
        gap = 0;
      end else if (!bus.out_busy[2] && gap >= 0) begin
        gap++;
      end
      prev_b = bus.out_busy[2];
    end
    chk("cont_count", 32'(order.size()), 32'd4);
    if (order.size() == 4) begin
      chk("cont_order0", 32'(order[0]), 32'd0);
      chk("cont_order1", 32'(order[1]), 32'd1);
      chk("cont_order2", 32'(order[2]), 32'd3);
      chk("cont_order3", 32'(order[3]), 32'd0);
    end
    foreach (gaps[k]) chk("cont_bubble", 32'(gaps[k]), 32'd1);

    // accept conflict: in0 -> out1/out3, in2 -> out1
    rq = 16'h020A;
    cycle(1'b1, rq, 4'h0, 4'hF);
    cycle(1'b0, rq, 4'h0, 4'hF);
    chk("conflict_match", 32'(bus.match), 32'h0002);
    cycle(1'b0, rq, 4'h0, 4'hF);
    cycle(1'b0, rq, 4'h0, 4'hF);
    chk("conflict_wait", 32'(bus.match), 32'h0002);
    cycle(1'b0, rq, 4'b0001, 4'hF);
    chk("conflict_release", 32'(bus.match), 32'h0);
    cycle(1'b0, rq, 4'h0, 4'hF);
    chk("conflict_rematch", 32'(bus.match), 32'h0208);

    // full permutation, released together, then rematched
    rq = 16'h1842;
    cycle(1'b1, rq, 4'h0, 4'hF);
    cycle(1'b0, rq, 4'h0, 4'hF);
    chk("perm_match", 32'(bus.match), 32'h1842);
    cycle(1'b0, rq, 4'hF, 4'hF);
    chk("perm_release_all", 32'(bus.match), 32'h0);
    cycle(1'b0, rq, 4'h0, 4'hF);
    chk("perm_rematch", 32'(bus.match), 32'h1842);

    // output pause, then reset mid-packet
    cycle(1'b1, 16'h0040, 4'h0, 4'b1011);
    cycle(1'b0, 16'h0040, 4'h0, 4'b1011);
    cycle(1'b0, 16'h0040, 4'h0, 4'b1011);
    chk("pause_nomatch", 32'(bus.match), 32'h0);
    cycle(1'b0, 16'h0040, 4'h0, 4'hF);
    chk("pause_resume", 32'(bus.match), 32'h0040);
    cycle(1'b0, 16'h0040, 4'h0, 4'b1011);
    chk("pause_lock_kept", 32'(bus.match), 32'h0040);
    cycle(1'b1, 16'h0040, 4'h0, 4'hF);
    chk("rst_mid_packet", 32'(bus.match), 32'h0);

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      cycle(($urandom_range(0, 99) == 0), 16'($urandom), 4'($urandom & $urandom),
            4'($urandom | $urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
